// File: rtl/flits_sender.sv
// Transmit side of the NIC flit link: holds one parallel packet and serialises it
// one flit per cycle, gated by downstream per-slot credits and a packet-level free flag.
module flits_sender #(
    parameter int FLIT_WIDTH        = 64,
    parameter int MAX_PACKET_LENGHT = 8,
    parameter int N_BITS_POINTER    = $clog2(MAX_PACKET_LENGHT),
    parameter int N_CREDITS         = 4,
    parameter int N_BITS_CREDIT     = $clog2(N_CREDITS + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0]   in_link_i,
    input  logic                                      r_msg_to_pkt_i,
    output logic                                      stall_msg_to_pkt_o,
    output logic [FLIT_WIDTH-1:0]                     out_link_o,
    output logic                                      is_valid_o,
    input  logic                                      credit_signal_i,
    input  logic                                      free_signal_i,
    output logic                                      err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FREE,
        SEND
    } state_t;

    localparam logic [1:0] TYPE_TAIL      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;
    localparam logic [N_BITS_POINTER-1:0] LAST_IDX   = N_BITS_POINTER'(MAX_PACKET_LENGHT - 1);
    localparam logic [N_BITS_CREDIT-1:0]  CREDIT_MAX = N_BITS_CREDIT'(N_CREDITS);

    state_t                                  state_q, state_d;
    logic [N_BITS_POINTER-1:0]               idx_q, idx_d;
    logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_q, pkt_d;
    logic [N_BITS_CREDIT-1:0]                credits_q, credits_d;
    logic                                    free_q, free_d;
    logic [FLIT_WIDTH-1:0]                   out_q, out_d;
    logic                                    valid_q, valid_d;
    logic                                    stall_q, stall_d;
    logic                                    err_q, err_d;

    logic [FLIT_WIDTH-1:0] flits [MAX_PACKET_LENGHT];
    logic [FLIT_WIDTH-1:0] cur_flit;
    logic [1:0]            cur_type;
    logic                  has_credit;
    logic                  issue;
    logic                  head_issue;

    always_comb begin
        for (int k = 0; k < MAX_PACKET_LENGHT; k++) begin
            flits[k] = pkt_q[k*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    assign cur_flit   = flits[idx_q];
    assign cur_type   = cur_flit[1:0];
    assign has_credit = (credits_q != '0);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pkt_d      = pkt_q;
        stall_d    = stall_q;
        err_d      = err_q;
        out_d      = '0;
        valid_d    = 1'b0;
        issue      = 1'b0;
        head_issue = 1'b0;

        case (state_q)
            IDLE: begin
                stall_d = 1'b0;
                if (r_msg_to_pkt_i) begin
                    pkt_d   = in_link_i;
                    idx_d   = '0;
                    stall_d = 1'b1;
                    state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (free_q && has_credit) begin
                    issue      = 1'b1;
                    head_issue = 1'b1;
                    if (cur_type == TYPE_HEAD_TAIL) begin
                        stall_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = N_BITS_POINTER'(1);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (has_credit) begin
                    issue = 1'b1;
                    if (cur_type == TYPE_TAIL || idx_q == LAST_IDX) begin
                        // A full-length packet without a tail is still sent, but flagged.
                        if (cur_type != TYPE_TAIL) begin
                            err_d = 1'b1;
                        end
                        idx_d   = '0;
                        stall_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + N_BITS_POINTER'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            out_d   = cur_flit;
            valid_d = 1'b1;
        end
    end

    // A credit returned in the same cycle as an issue cancels it out.
    always_comb begin
        credits_d = credits_q;
        if (issue && !credit_signal_i) begin
            credits_d = credits_q - N_BITS_CREDIT'(1);
        end else if (!issue && credit_signal_i && credits_q != CREDIT_MAX) begin
            credits_d = credits_q + N_BITS_CREDIT'(1);
        end
    end

    always_comb begin
        free_d = free_q;
        if (head_issue) begin
            free_d = 1'b0;
        end else if (free_signal_i) begin
            free_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pkt_q     <= '0;
            credits_q <= CREDIT_MAX;
            free_q    <= 1'b1;
            out_q     <= '0;
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pkt_q     <= pkt_d;
            credits_q <= credits_d;
            free_q    <= free_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

    assign out_link_o         = out_q;
    assign is_valid_o         = valid_q;
    assign stall_msg_to_pkt_o = stall_q;
    assign err_o              = err_q;

endmodule

// File: doc/flits_sender.md
# flits_sender

Transmit side of the NIC flit link, mirroring `flits_buffer` on the receive end. It accepts one whole packet (up to `MAX_PACKET_LENGHT` flits, parallel) from the message-to-packet stage and serialises it one flit per cycle onto the outgoing link. Flow control is credit-based: a per-slot credit return comes from the downstream buffer, and a packet-level free indication gates each head flit. The block sits between the message-to-packet stage and the router input port.

## Interface
- `FLIT_WIDTH`, 64, flit width in bits; bits [1:0] of each flit carry the flit type.
- `MAX_PACKET_LENGHT`, 8, maximum flits per packet.
- `N_BITS_POINTER`, clog2(`MAX_PACKET_LENGHT`), width of the flit index.
- `N_CREDITS`, 4, downstream buffer slots (credit counter reset value and ceiling).
- `N_BITS_CREDIT`, clog2(`N_CREDITS`+1), width of the credit counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_link_i` in `MAX_PACKET_LENGHT*FLIT_WIDTH`: packet; flit k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH]; flit 0 is the head.
- `r_msg_to_pkt_i` in 1: packet request/valid from upstream.
- `stall_msg_to_pkt_o` out 1: busy; a packet is held and not yet fully sent.
- `out_link_o` out `FLIT_WIDTH`: outgoing flit.
- `is_valid_o` out 1: `out_link_o` carries a flit this cycle.
- `credit_signal_i` in 1: 1-cycle pulse, one downstream slot freed.
- `free_signal_i` in 1: 1-cycle pulse, downstream packet buffer fully drained.
- `err_o` out 1: sticky; set when a packet reaches `MAX_PACKET_LENGHT` flits without a tail flit.

## Operation
- Flit type (bits [1:0]): 00 head, 01 body, 10 tail, 11 head+tail (single-flit packet).
- State machine states: IDLE, WAIT_FREE, SEND.
- **IDLE**
  - `stall_msg_to_pkt_o`=0.
  - `r_msg_to_pkt_i`=1 at an edge: latch `in_link_i`, set index=0, set stall, go to WAIT_FREE.
- **WAIT_FREE**
  - When `free_flag`=1 and credits>0: issue flit 0.
  - Clear `free_flag`.
  - If flit 0 is head+tail: go to IDLE. Otherwise: index=1, go to SEND.
- **SEND**
  - When credits>0: issue flit[index].
  - If the issued flit is a tail, or index=`MAX_PACKET_LENGHT`-1: go to IDLE.
  - Otherwise: index++.
  - Issuing at index `MAX_PACKET_LENGHT`-1 with a type other than tail sets `err_o`; that flit is sent unchanged.
- **Issue rule:** at the issuing edge, `out_link_o`←flit and `is_valid_o`←1. On every non-issuing edge, `is_valid_o`←0 and `out_link_o`←0.
- **Credit counter:**
  - Issue only: −1.
  - `credit_signal_i` only: +1, saturating at `N_CREDITS` (excess pulses ignored).
  - Both in the same cycle: unchanged.
  - The counter never underflows, because issue requires credits>0.
- **`free_flag`:**
  - Set by reset and by a `free_signal_i` pulse.
  - Cleared on head issue.
  - If the pulse coincides with a head issue, clear wins and the pulse is dropped.
- Latched packet data holds stable from accept until return to IDLE; `in_link_i` is ignored while stall=1.

## Timing
- **Reset values:** state IDLE, `out_link_o`=0, `is_valid_o`=0, `stall_msg_to_pkt_o`=0, `err_o`=0, credits=`N_CREDITS`, `free_flag`=1, index=0.
- **Reset mid-packet:** immediate return to the reset values; the partial packet is abandoned.
- All outputs are registered.
- **Accept:** at edge T, stall is high from T.
- **Head latency:** earliest head is at edge T+1 (`is_valid_o` high during the cycle after T+1).
- **Throughput:** one flit per cycle while credits>0. A zero-credit cycle inserts a bubble (`is_valid_o`=0); a credit pulse in cycle C allows issue at the edge ending C+1.
- **End of packet:** stall drops at the tail-issue edge. The next accept is at the following edge at the earliest; its head also waits for `free_flag`.

## Test plan
- **Single flit:** packet with flit 0 = 0xFF3 (head+tail) after reset → exactly one `is_valid_o` cycle carrying 0xFF3. Credits 4→3, stall high 1 cycle, `free_flag` cleared.
- **Credit stall, 5-flit packet:** flits 0x30, 0x41, 0x51, 0x61, 0x72, no credit returns → 0x30, 0x41, 0x51, 0x61 on 4 consecutive cycles, then `is_valid_o`=0 and credits=0. One `credit_signal_i` pulse → 0x72 sent next edge, stall drops.
- **Back-to-back packets:** second request arrives during the first tail cycle → accepted at the next edge. Its head is held until `free_signal_i` pulses, then issued at the following edge.
- **Simultaneous credit return and issue:** credits stay constant across a 3-flit stream with a pulse every cycle. Extra pulses at credits=4 → remain 4.
- **Missing tail:** 8 body flits (type 01) → all 8 sent, `err_o`=1 after the 8th, return to IDLE. `err_o` stays 1 until reset.
- **Reset mid-packet:** `rst`=0 after flit 2 of 5 → outputs at reset values immediately, credits=4, no further flits. A new packet after release sends correctly.
